// File: rtl/butterfly_r2_pipe_pkg.sv
// Shared widths and arithmetic helpers for the radix-2 butterfly datapath.
// Saturation works on a 64-bit signed container so any W up to 63 can use it.
package butterfly_r2_pipe_pkg;

    localparam int W_DEFAULT  = 16;
    localparam int TW_DEFAULT = 16;

    // Half an LSB of the Q1.(TW-1) product scaling, used for round-half-up.
    function automatic logic signed [63:0] round_const(input int tw);
        return 64'sd1 <<< (tw - 2);
    endfunction

    function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = ~hi;
        res = x;
        if (x > hi) begin
            res = hi;
        end else if (x < lo) begin
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/butterfly_r2_pipe_cmul.sv
// Two-stage complex multiply b*w (or b*conj(w)) with round-half-up and
// saturation to W bits; reports a saturation event alongside the result.
module cmul_round_pipe
    import butterfly_r2_pipe_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int TW = TW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 inverse,
    input  logic signed [W-1:0]  br,
    input  logic signed [W-1:0]  bi,
    input  logic signed [TW-1:0] wr,
    input  logic signed [TW-1:0] wi,
    output logic                 out_valid,
    output logic signed [W-1:0]  bwr,
    output logic signed [W-1:0]  bwi,
    output logic                 sat_evt
);

    localparam int PW = W + TW;
    localparam int SW = PW + 2;
    localparam logic signed [SW-1:0] RC = SW'(round_const(TW));

    logic signed [PW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic                 v1_q, inv1_q;

    logic signed [SW-1:0] rr, ii, ri, ir;
    logic signed [SW-1:0] sum_r, sum_i, rnd_r, rnd_i;
    logic signed [63:0]   ext_r, ext_i, sat_r, sat_i;
    logic signed [W-1:0]  bwr_d, bwi_d, bwr_q, bwi_q;
    logic                 evt_d, evt_q, v2_q;

    always_comb begin
        p_rr_d = $signed({{TW{br[W-1]}}, br}) * $signed({{W{wr[TW-1]}}, wr});
        p_ii_d = $signed({{TW{bi[W-1]}}, bi}) * $signed({{W{wi[TW-1]}}, wi});
        p_ri_d = $signed({{TW{br[W-1]}}, br}) * $signed({{W{wi[TW-1]}}, wi});
        p_ir_d = $signed({{TW{bi[W-1]}}, bi}) * $signed({{W{wr[TW-1]}}, wr});
    end

    // Conjugation negates product terms rather than wi so wi = -2^(TW-1) stays exact.
    always_comb begin
        rr = {{2{p_rr_q[PW-1]}}, p_rr_q};
        ii = {{2{p_ii_q[PW-1]}}, p_ii_q};
        ri = {{2{p_ri_q[PW-1]}}, p_ri_q};
        ir = {{2{p_ir_q[PW-1]}}, p_ir_q};
        if (inv1_q) begin
            sum_r = rr + ii;
            sum_i = ir - ri;
        end else begin
            sum_r = rr - ii;
            sum_i = ri + ir;
        end
        rnd_r = (sum_r + RC) >>> (TW - 1);
        rnd_i = (sum_i + RC) >>> (TW - 1);
        ext_r = {{(64 - SW){rnd_r[SW-1]}}, rnd_r};
        ext_i = {{(64 - SW){rnd_i[SW-1]}}, rnd_i};
        sat_r = sat_to_w(ext_r, W);
        sat_i = sat_to_w(ext_i, W);
        bwr_d = sat_r[W-1:0];
        bwi_d = sat_i[W-1:0];
        evt_d = (sat_r != ext_r) || (sat_i != ext_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
            v1_q   <= 1'b0;
            inv1_q <= 1'b0;
            bwr_q  <= '0;
            bwi_q  <= '0;
            evt_q  <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
            v1_q   <= in_valid;
            inv1_q <= inverse;
            bwr_q  <= bwr_d;
            bwi_q  <= bwi_d;
            evt_q  <= evt_d;
            v2_q   <= v1_q;
        end
    end

    assign out_valid = v2_q;
    assign bwr       = bwr_q;
    assign bwi       = bwi_q;
    assign sat_evt   = evt_q;

endmodule

// File: rtl/butterfly_r2_pipe.sv
// Pipelined radix-2 DIT butterfly, y0 = a + b*w, y1 = a - b*w, latency 3,
// with per-sample conj/scale modes and a sticky overflow flag.
module butterfly_r2_pipe
    import butterfly_r2_pipe_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int TW = TW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [W-1:0]  ar,
    input  logic signed [W-1:0]  ai,
    input  logic signed [W-1:0]  br,
    input  logic signed [W-1:0]  bi,
    input  logic signed [TW-1:0] wr,
    input  logic signed [TW-1:0] wi,
    input  logic                 inverse,
    input  logic                 scale,
    input  logic                 ovf_clr,
    output logic                 out_valid,
    output logic signed [W-1:0]  y0r,
    output logic signed [W-1:0]  y0i,
    output logic signed [W-1:0]  y1r,
    output logic signed [W-1:0]  y1i,
    output logic                 ovf
);

    logic signed [W-1:0] ar1_d, ai1_d, ar1_q, ai1_q;
    logic signed [W-1:0] ar2_d, ai2_d, ar2_q, ai2_q;
    logic                scale1_d, scale1_q, scale2_d, scale2_q;

    logic                v2;
    logic signed [W-1:0] bwr, bwi;
    logic                cm_evt;
    logic                lane_evt;
    logic                ovf_d, ovf_q, out_valid_d, out_valid_q;

    cmul_round_pipe #(.W(W), .TW(TW)) u_cmul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .inverse   (inverse),
        .br        (br),
        .bi        (bi),
        .wr        (wr),
        .wi        (wi),
        .out_valid (v2),
        .bwr       (bwr),
        .bwi       (bwi),
        .sat_evt   (cm_evt)
    );

    // a and scale ride two stages so they meet the multiplier result at S3.
    always_comb begin
        ar1_d    = ar;
        ai1_d    = ai;
        scale1_d = scale;
        ar2_d    = ar1_q;
        ai2_d    = ai1_q;
        scale2_d = scale1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar1_q    <= '0;
            ai1_q    <= '0;
            scale1_q <= 1'b0;
            ar2_q    <= '0;
            ai2_q    <= '0;
            scale2_q <= 1'b0;
        end else begin
            ar1_q    <= ar1_d;
            ai1_q    <= ai1_d;
            scale1_q <= scale1_d;
            ar2_q    <= ar2_d;
            ai2_q    <= ai2_d;
            scale2_q <= scale2_d;
        end
    end

    // Lanes: 0 = y0r, 1 = y0i, 2 = y1r, 3 = y1i.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic signed [W-1:0] a_l, b_l;
            logic signed [W:0]   s_l;
            logic signed [63:0]  ext_l, sat_l;
            logic signed [W-1:0] y_d, y_q;
            logic                evt_l;

            always_comb begin
                a_l = ((gi % 2) == 0) ? ar2_q : ai2_q;
                b_l = ((gi % 2) == 0) ? bwr : bwi;
                if (gi < 2) begin
                    s_l = {a_l[W-1], a_l} + {b_l[W-1], b_l};
                end else begin
                    s_l = {a_l[W-1], a_l} - {b_l[W-1], b_l};
                end
                ext_l = {{(63 - W){s_l[W]}}, s_l};
                sat_l = sat_to_w(ext_l, W);
                y_d   = y_q;
                evt_l = 1'b0;
                if (v2) begin
                    if (scale2_q) begin
                        y_d = s_l[W:1];
                    end else begin
                        y_d   = sat_l[W-1:0];
                        evt_l = (sat_l != ext_l);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    y_q <= '0;
                end else begin
                    y_q <= y_d;
                end
            end
        end
    endgenerate

    assign lane_evt = g_lane[0].evt_l | g_lane[1].evt_l | g_lane[2].evt_l | g_lane[3].evt_l;

    // A set on the same edge as a clear takes priority.
    always_comb begin
        out_valid_d = v2;
        ovf_d       = (ovf_q & ~ovf_clr) | (v2 & (cm_evt | lane_evt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign y0r       = g_lane[0].y_q;
    assign y0i       = g_lane[1].y_q;
    assign y1r       = g_lane[2].y_q;
    assign y1i       = g_lane[3].y_q;

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Scoreboard bench for butterfly_r2_pipe: directed corner cases, random
// streaming with gaps, sticky overflow behaviour and mid-stream reset.
module tb_butterfly_r2_pipe;

    localparam int W  = 16;
    localparam int TW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 inverse = 1'b0;
    logic                 scale = 1'b0;
    logic                 ovf_clr = 1'b0;
    logic signed [W-1:0]  ar = '0, ai = '0, br = '0, bi = '0;
    logic signed [TW-1:0] wr = '0, wi = '0;
    logic                 out_valid, ovf;
    logic signed [W-1:0]  y0r, y0i, y1r, y1i;

    always #5 clk = ~clk;

    butterfly_r2_pipe #(.W(W), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .ar        (ar),
        .ai        (ai),
        .br        (br),
        .bi        (bi),
        .wr        (wr),
        .wi        (wi),
        .inverse   (inverse),
        .scale     (scale),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .y0r       (y0r),
        .y0i       (y0i),
        .y1r       (y1r),
        .y1i       (y1i),
        .ovf       (ovf)
    );

    typedef struct {
        int y0r;
        int y0i;
        int y1r;
        int y1i;
        bit evt;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cycle = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   exp_valid = 1'b0;
    bit   ovf_m = 1'b0;
    int   hold[4] = '{0, 0, 0, 0};

    // Clamp to the signed W-bit range, flagging when clamping happened.
    function automatic longint sat_w(input longint x, inout bit e);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -hi - 1;
        if (x > hi) begin e = 1'b1; return hi; end
        if (x < lo) begin e = 1'b1; return lo; end
        return x;
    endfunction

    // Reference: complex product, round half up in Q1.(TW-1), then a +/- b*w.
    function automatic exp_t model(input longint a_r, a_i, b_r, b_i, w_r, w_i,
                                   input bit inv, sc);
        exp_t   x;
        longint pr, pi, bwr_m, bwi_m, half;
        longint s[4];
        longint y[4];
        bit     e;
        e = 1'b0;
        half = longint'(1) <<< (TW - 2);
        if (!inv) begin
            pr = b_r * w_r - b_i * w_i;
            pi = b_r * w_i + b_i * w_r;
        end else begin
            pr = b_r * w_r + b_i * w_i;
            pi = b_i * w_r - b_r * w_i;
        end
        bwr_m = sat_w((pr + half) >>> (TW - 1), e);
        bwi_m = sat_w((pi + half) >>> (TW - 1), e);
        s[0] = a_r + bwr_m;
        s[1] = a_i + bwi_m;
        s[2] = a_r - bwr_m;
        s[3] = a_i - bwi_m;
        for (int k = 0; k < 4; k++) begin
            if (sc) y[k] = s[k] >>> 1;
            else    y[k] = sat_w(s[k], e);
        end
        x.y0r = int'(y[0]);
        x.y0i = int'(y[1]);
        x.y1r = int'(y[2]);
        x.y1i = int'(y[3]);
        x.evt = e;
        x.due = 0;
        return x;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cycle, got, exp);
        end
    endtask

    // One input cycle. When dir is set the hand-computed expectation is used.
    task automatic step(input bit v, input int a_r, a_i, b_r, b_i, w_r, w_i,
                        input bit inv, sc, clr,
                        input bit dir, input int e0r, e0i, e1r, e1i, input bit eevt);
        exp_t x;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = v;
        ar       = W'(a_r);
        ai       = W'(a_i);
        br       = W'(b_r);
        bi       = W'(b_i);
        wr       = TW'(w_r);
        wi       = TW'(w_i);
        inverse  = inv;
        scale    = sc;
        ovf_clr  = clr;
        if (v) begin
            if (dir) begin
                x.y0r = e0r; x.y0i = e0i; x.y1r = e1r; x.y1i = e1i; x.evt = eevt;
            end else begin
                x = model(a_r, a_i, b_r, b_i, w_r, w_i, inv, sc);
            end
            x.due = cycle + 3;
            sb.push_back(x);
        end
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic rand_step(input bit v, input bit clr);
        step(v, rnd_s(), rnd_s(), rnd_s(), rnd_s(), rnd_s(), rnd_s(),
             1'(($urandom_range(1))), 1'(($urandom_range(1))), clr, 1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic idle(input bit clr);
        rand_step(1'b0, clr);
    endtask

    // Model state advances on each edge, mirroring what the edge should commit.
    always @(posedge clk) begin
        exp_t x;
        bit   evt;
        cycle++;
        evt = 1'b0;
        exp_valid = 1'b0;
        if (rst) begin
            sb.delete();
            ovf_m = 1'b0;
            for (int k = 0; k < 4; k++) hold[k] = 0;
        end else begin
            if (sb.size() > 0 && sb[0].due == cycle) begin
                x = sb.pop_front();
                hold[0] = x.y0r;
                hold[1] = x.y0i;
                hold[2] = x.y1r;
                hold[3] = x.y1i;
                evt = x.evt;
                exp_valid = 1'b1;
            end
            ovf_m = (ovf_m && !ovf_clr) || evt;
        end
    end

    always @(negedge clk) begin
        if (cycle > 0) begin
            chk("out_valid", int'(out_valid), int'(exp_valid));
            chk("y0r", int'(y0r), hold[0]);
            chk("y0i", int'(y0i), hold[1]);
            chk("y1r", int'(y1r), hold[2]);
            chk("y1i", int'(y1i), hold[3]);
            chk("ovf", int'(ovf), int'(ovf_m));
            if (exp_valid)
                $display("txn cyc=%0d y0=(%0d,%0d) y1=(%0d,%0d) ovf=%0b",
                         cycle, y0r, y0i, y1r, y1i, ovf);
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // Forward, scaled: w = -1.0
        step(1, 1000, 0, 200, 0, -32768, 0, 0, 1, 0, 1, 400, 0, 600, 0, 0);
        // Pure imaginary twiddle, forward then inverse
        step(1, 0, 0, 100, 0, 0, -32768, 0, 0, 0, 1, 0, -100, 0, 100, 0);
        step(1, 0, 0, 100, 0, 0, -32768, 1, 0, 0, 1, 0, 100, 0, -100, 0);
        repeat (4) idle(0);

        // Output saturation; flag must stay up until cleared
        step(1, 30000, 0, -30000, 0, -32768, 0, 0, 0, 0, 1, 32767, 0, 0, 0, 1);
        repeat (6) idle(0);
        idle(1);
        repeat (2) idle(0);

        // Product corner with clear landing on the same edge as the new overflow
        step(1, 0, 0, -32768, 0, -32768, 0, 0, 1, 0, 1, 16383, 0, -16384, 0, 1);
        idle(0);
        idle(1);
        repeat (3) idle(0);
        idle(1);
        repeat (2) idle(0);

        // Random streaming with gaps and occasional clears
        for (int n = 0; n < 300; n++)
            rand_step($urandom_range(3) != 0, $urandom_range(15) == 0);
        repeat (4) idle(0);

        // Raise ovf, then reset with two samples in flight
        step(1, 0, 0, -32768, 0, -32768, 0, 0, 1, 0, 1, 16383, 0, -16384, 0, 1);
        repeat (3) idle(0);
        rand_step(1, 0);
        rand_step(1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
        rst      = 1'b1;
        step(1, 1000, 0, 200, 0, -32768, 0, 0, 1, 0, 1, 400, 0, 600, 0, 0);
        repeat (6) idle(0);

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
